// File: rtl/icache_refill_bridge_if.sv
// icache_refill_bridge bus bundle: ICache refill link plus AXI AR/R.
// slave = bridge view, master = ICache/AXI-side view.
interface icache_refill_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              ret_valid;
  logic [255:0]      ret_data;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arid;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              refill_err;

  modport slave (
    input  rd_req, rd_addr,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output ret_valid, ret_data,
    output arvalid, araddr, arlen,
    output arsize, arburst, arid,
    output rready, refill_err
  );

  modport master (
    output rd_req, rd_addr,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  ret_valid, ret_data,
    input  arvalid, araddr, arlen,
    input  arsize, arburst, arid,
    input  rready, refill_err
  );
endinterface

// File: rtl/icache_refill_bridge.sv
// ICache line refill: one 8-beat INCR AXI read, line returned in one pulse.
// Optional perf counters under `ICACHE_REFILL_PERF_EN.
module icache_refill_bridge #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input logic clk,
  input logic rst,
  icache_refill_bridge_if.slave bus
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0] refill_cnt,
  output logic [31:0] refill_cycles
`endif
);

  localparam int LINE_W = LINE_WORDS * 32;
  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFS_MASK =
    ADDR_W'(LINE_W / 8 - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;
  localparam logic [1:0] RET  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] ret_q, ret_d;
  logic              err_q, err_d;
  logic              last_beat;

  assign last_beat = (beat_q == LAST);

  // Next-state: request latch, AR handshake, beat gather, return.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    araddr_d = araddr_q;
    line_d   = line_q;
    ret_d    = ret_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          araddr_d = bus.rd_addr & ~OFS_MASK;
          state_d  = AR;
        end
      end
      AR: begin
        if (bus.arready) begin
          state_d = R;
          beat_d  = '0;
        end
      end
      R: begin
        if (bus.rvalid) begin
          line_d[{beat_q, 5'd0} +: 32] = bus.rdata;
          if (bus.rresp != 2'b00) err_d = 1'b1;
          if (bus.rlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            state_d = RET;
            beat_d  = '0;
            ret_d   = line_d;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      RET: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      araddr_q <= '0;
      line_q   <= '0;
      ret_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      araddr_q <= araddr_d;
      line_q   <= line_d;
      ret_q    <= ret_d;
      err_q    <= err_d;
    end
  end

  assign bus.arvalid    = (state_q == AR);
  assign bus.rready     = (state_q == R);
  assign bus.ret_valid  = (state_q == RET);
  assign bus.ret_data   = ret_q;
  assign bus.araddr     = araddr_q;
  assign bus.arlen      = 8'(LINE_WORDS - 1);
  assign bus.arsize     = 3'b010;
  assign bus.arburst    = 2'b01;
  assign bus.arid       = 4'd0;
  assign bus.refill_err = err_q;

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] cnt_q;
  logic [31:0] cyc_q;

  // Refill count and busy-cycle count, both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      if (state_q == RET) cnt_q <= cnt_q + 32'd1;
      if (state_q != IDLE) cyc_q <= cyc_q + 32'd1;
    end
  end

  assign refill_cnt    = cnt_q;
  assign refill_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Directed bench for icache_refill_bridge with a small AXI slave model.
// Perf counter check only when ICACHE_REFILL_PERF_EN is defined.
module tb_icache_refill_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_refill_bridge_if #(.ADDR_W(32)) bus ();

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] refill_cnt;
  logic [31:0] refill_cycles;
`endif

  icache_refill_bridge #(
    .LINE_WORDS(8),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ICACHE_REFILL_PERF_EN
    ,
    .refill_cnt(refill_cnt),
    .refill_cycles(refill_cycles)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    int          ar_delay;
    bit          toggle;
    int          err_beat;
    int          rlast_beat;
    bit          rst_first;
    bit          drop_req;
    logic [31:0] exp_araddr;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_xfer(input vec_t v);
    int cyc = 0;
    int beat = 0;
    int arcyc = 0;
    int pulses = 0;
    int lat = -1;
    bit hs = 1'b0;
    bit ph = 1'b1;
    bit addr_ok = 1'b1;
    bit early_r = 1'b0;
    logic [255:0] exp_line;
    for (int i = 0; i < 8; i++)
      exp_line[32*i +: 32] = v.base + 32'(i);
    if (v.rst_first) do_rst();
    bus.rd_req  = 1'b1;
    bus.rd_addr = v.addr;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    while (lat < 0 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (v.drop_req) bus.rd_req = 1'b0;
      if (bus.ret_valid) begin
        lat = cyc;
        pulses++;
      end
      if (bus.rready && !hs) early_r = 1'b1;
      if (bus.arvalid) begin
        arcyc++;
        if (bus.araddr !== v.exp_araddr)
          addr_ok = 1'b0;
        bus.arready = (arcyc > v.ar_delay);
      end else begin
        bus.arready = 1'b0;
      end
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      bus.rresp  = 2'b00;
      bus.rdata  = 32'h0;
      if (hs && beat < 8) begin
        bus.rvalid = v.toggle ? ph : 1'b1;
        ph = ~ph;
        bus.rdata = v.base + 32'(beat);
        bus.rresp = (beat == v.err_beat) ?
                    2'b10 : 2'b00;
        bus.rlast = (beat == v.rlast_beat);
        if (bus.rvalid && bus.rready) beat++;
      end
      if (bus.arvalid && bus.arready) hs = 1'b1;
    end
    chk("timeout", 256'(lat >= 0), 256'(1));
    chk("latency", 256'(lat), 256'(v.exp_lat));
    chk("araddr", 256'(addr_ok), 256'(1));
    chk("ar_cycles", 256'(arcyc),
        256'(v.ar_delay + 1));
    chk("rready_early", 256'(early_r), 256'(0));
    chk("ret_data", bus.ret_data, exp_line);
    chk("refill_err", 256'(bus.refill_err),
        256'(v.exp_err));
    bus.rd_req = 1'b0;
    bus.rvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("ret_single", 256'(bus.ret_valid), 256'(0));
    chk("rready_idle", 256'(bus.rready), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("ret_hold", bus.ret_data, exp_line);
    chk("arvalid_idle", 256'(bus.arvalid), 256'(0));
    chk("pulses", 256'(pulses), 256'(1));
  endtask

  initial begin
    int beat;
    bit hs;
    tbl[0] = '{32'h1C00_0034, 32'h0000_0100, 0, 1'b0,
               -1, 7, 1'b0, 1'b0, 32'h1C00_0020, 10, 1'b0};
    tbl[1] = '{32'h8000_001F, 32'h0000_A000, 5, 1'b0,
               -1, 7, 1'b0, 1'b0, 32'h8000_0000, 15, 1'b0};
    tbl[2] = '{32'h0000_0040, 32'h55AA_0000, 0, 1'b1,
               -1, 7, 1'b0, 1'b0, 32'h0000_0040, 17, 1'b0};
    tbl[3] = '{32'hFFFF_FFFC, 32'hDEAD_0000, 0, 1'b0,
               -1, 7, 1'b0, 1'b0, 32'hFFFF_FFE0, 10, 1'b0};
    tbl[4] = '{32'h1234_5678, 32'h0000_3000, 0, 1'b0,
               3, 7, 1'b0, 1'b0, 32'h1234_5660, 10, 1'b1};
    tbl[5] = '{32'h0000_0004, 32'h0000_4000, 2, 1'b0,
               -1, 7, 1'b0, 1'b0, 32'h0000_0000, 12, 1'b1};
    tbl[6] = '{32'h0000_ABCD, 32'h0000_5000, 0, 1'b0,
               -1, 7, 1'b1, 1'b0, 32'h0000_ABC0, 10, 1'b0};
    tbl[7] = '{32'h0000_1000, 32'h0000_6000, 0, 1'b0,
               -1, 2, 1'b0, 1'b0, 32'h0000_1000, 10, 1'b1};
    tbl[8] = '{32'h0000_2024, 32'h0000_7000, 1, 1'b1,
               -1, 7, 1'b1, 1'b1, 32'h0000_2020, 18, 1'b0};

    rst         = 1'b1;
    bus.rd_req  = 1'b0;
    bus.rd_addr = 32'h0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'h0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ret_valid", 256'(bus.ret_valid), 256'(0));
    chk("rst_ret_data", bus.ret_data, 256'(0));
    chk("rst_arvalid", 256'(bus.arvalid), 256'(0));
    chk("rst_araddr", 256'(bus.araddr), 256'(0));
    chk("rst_rready", 256'(bus.rready), 256'(0));
    chk("rst_err", 256'(bus.refill_err), 256'(0));
    chk("arlen", 256'(bus.arlen), 256'(7));
    chk("arsize", 256'(bus.arsize), 256'(2));
    chk("arburst", 256'(bus.arburst), 256'(1));
    chk("arid", 256'(bus.arid), 256'(0));

    for (int i = 0; i < 9; i++) do_xfer(tbl[i]);

    // Reset in the middle of a burst with error beats.
    do_rst();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'h0000_3000;
    bus.arready = 1'b1;
    beat = 0;
    hs = 1'b0;
    for (int c = 0; c < 40 && beat < 4; c++) begin
      @(posedge clk);
      #1;
      bus.rvalid = hs;
      bus.rdata  = 32'hBAD0_0000 + 32'(beat);
      bus.rresp  = 2'b11;
      bus.rlast  = 1'b0;
      if (bus.rvalid && bus.rready) beat++;
      if (bus.arvalid && bus.arready) hs = 1'b1;
    end
    chk("mid_beats", 256'(beat), 256'(4));
    @(posedge clk);
    #1;
    chk("mid_err_pre", 256'(bus.refill_err), 256'(1));
    chk("mid_rready_pre", 256'(bus.rready), 256'(1));
    rst = 1'b1;
    bus.rd_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rresp   = 2'b00;
    bus.arready = 1'b0;
    chk("mid_rready", 256'(bus.rready), 256'(0));
    chk("mid_arvalid", 256'(bus.arvalid), 256'(0));
    chk("mid_ret_valid", 256'(bus.ret_valid), 256'(0));
    chk("mid_err", 256'(bus.refill_err), 256'(0));
    do_xfer(tbl[0]);

`ifdef ICACHE_REFILL_PERF_EN
    do_rst();
    chk("perf_rst_cnt", 256'(refill_cnt), 256'(0));
    chk("perf_rst_cyc", 256'(refill_cycles), 256'(0));
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'h0000_0100;
    bus.arready = 1'b1;
    bus.rvalid  = 1'b0;
    beat = 0;
    hs = 1'b0;
    begin
      int pulses = 0;
      for (int c = 0; c < 22; c++) begin
        @(posedge clk);
        #1;
        if (bus.ret_valid) pulses++;
        if (pulses == 2) bus.rd_req = 1'b0;
        bus.rvalid = hs;
        bus.rlast  = (beat == 7);
        bus.rresp  = 2'b00;
        bus.rdata  = 32'(beat);
        if (bus.rvalid && bus.rready) begin
          beat++;
          if (beat == 8) begin
            beat = 0;
            hs = 1'b0;
          end
        end
        if (bus.arvalid && bus.arready) hs = 1'b1;
      end
      chk("perf_pulses", 256'(pulses), 256'(2));
    end
    bus.rvalid = 1'b0;
    chk("perf_cnt", 256'(refill_cnt), 256'(2));
    chk("perf_cycles", 256'(refill_cycles), 256'(20));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_refill_bridge.md
Name: icache_refill_bridge

Overview:
Slave side of the icache_mem link. Takes one cache-line refill request from the ICache and issues one 8-beat, 32-bit INCR burst on the AXI read channel. It gathers the beats into a 256-bit line and returns the line with a one-cycle ret_valid pulse. Sits between the ICache and the AXI read arbiter.

Parameters:
LINE_WORDS, 8, number of 32-bit words per line (fixed at 8 to match bus256_t)
ADDR_W, 32, address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rd_req  input  1  refill request; held high by the ICache until ret_valid
rd_addr  input  32  miss address (any byte offset)
ret_valid  output  1  one-cycle pulse; ret_data valid
ret_data  output  256  refilled line; word i at [32*i+31:32*i]
arvalid  output  1  AXI AR valid
arready  input  1  AXI AR ready
araddr  output  32  burst start address, line-aligned
arlen  output  8  constant 8'd7
arsize  output  3  constant 3'b010
arburst  output  2  constant 2'b01 (INCR)
arid  output  4  constant 4'd0
rvalid  input  1  AXI R valid
rready  output  1  AXI R ready
rdata  input  32  AXI R data
rresp  input  2  AXI R response
rlast  input  1  AXI R last
refill_err  output  1  sticky error flag

Behaviour:
- The interface follows the decided rule: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: ret_valid=0, ret_data=0, arvalid=0, araddr=0, rready=0, refill_err=0, FSM=IDLE, beat_cnt=0. The arlen, arsize, arburst and arid outputs are constants.
- FSM states: IDLE, AR, R, RET.
- IDLE: when rd_req=1 and ret_valid=0, latch araddr={rd_addr[31:5],5'b0} and go to AR. arvalid rises in the next cycle.
- AR: arvalid=1. araddr is held stable until the cycle where arvalid&&arready. That handshake moves the FSM to R with beat_cnt=0. Dropping arvalid before the handshake is forbidden.
- R: rready=1. On each rvalid&&rready, write rdata into line_buf word beat_cnt and increment beat_cnt.
  - When the beat with beat_cnt==7 is accepted, go to RET.
  - If rresp!=2'b00 on any beat, set refill_err. The burst still completes.
  - If rlast=1 on a beat other than beat 7, or rlast=0 on beat 7, set refill_err. Counting decides completion; rlast does not.
- RET: ret_valid=1 and ret_data=line_buf for exactly one cycle, then IDLE. rready=0 outside the R state.
- Back-to-back requests: rd_req sampled in the cycle after RET (the IDLE cycle) starts a new request. The minimum gap between ret_valid pulses is AR latency + 8 beats + 2.
- Latency with arready and rvalid held high: request seen in cycle 0, arvalid in cycle 1 (handshake), beats in cycles 2–9, ret_valid in cycle 10.
- rd_req deasserted mid-transaction is ignored. The burst completes and ret_valid still pulses, because the AXI burst cannot be cancelled.
- ret_data holds its last value after RET.
- refill_err clears only on rst.
- rst asserted mid-burst returns the FSM to IDLE immediately. The external AXI slave must also be reset in the same cycle.
- Only one outstanding transaction exists at any time.

Optional Feature:
Macro ICACHE_REFILL_PERF_EN.
- Defined: adds output ports refill_cnt (32 bits) and refill_cycles (32 bits), both reset to 0.
  - refill_cnt increments on each ret_valid pulse.
  - refill_cycles increments every cycle the FSM is not IDLE.
  - Both counters wrap modulo 2^32.
- Undefined: the two ports and counters do not exist. All other behaviour is identical.

Test Plan:
- rd_addr=0x1C00_0034, arready=1, rvalid=1 every cycle, rdata=0x100+i for beat i → araddr=0x1C00_0020, arlen=7, ret_valid in cycle 10, ret_data word i = 0x100+i.
- arready held low for 5 cycles → arvalid and araddr stable for 6 cycles; no rready before the AR handshake; ret_data correct.
- rvalid toggled 1,0,1,0… with rlast on beat 7 → all 8 words are placed in order; ret_valid once; refill_err=0.
- rresp=2'b10 on beat 3 → the burst completes, ret_valid pulses, refill_err=1 and stays 1 until rst.
- rst asserted at beat 4 → next cycle FSM is IDLE and rready=0. A new request, with the AXI model reset, yields correct data and refill_err=0.
- ICACHE_REFILL_PERF_EN defined, two back-to-back refills with zero wait states → refill_cnt=2, refill_cycles=20.
